// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared widths, port indices and the read-tag type for the dmem arbiter
// Contents:
//   ADDR_W / DATA_W : default dmem word-address and data widths
//   PORT_CPU        : index of the processor data port (0)
//   PORT_LOAD       : index of the program/data loader port (1)
//   tag_t           : read-response tag carried through the pipeline (valid, port)
package dmem_arb_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    localparam logic PORT_CPU  = 1'b0;
    localparam logic PORT_LOAD = 1'b1;

    typedef struct packed {
        logic valid;
        logic port;
    } tag_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin arbiter with one-hot combinational grant
// Ports:
//   clock      in  : rising-edge clock
//   ctrl_reset in  : asynchronous active-low reset (rr pointer -> port 0)
//   req[1:0]   in  : request valids
//   accept     in  : a granted request is being taken this cycle
//   gnt[1:0]   out : one-hot grant, only offered to a requesting port
module rr_arbiter2 (
    input  logic       clock,
    input  logic       ctrl_reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);
    import dmem_arb_pkg::PORT_CPU;
    import dmem_arb_pkg::PORT_LOAD;

    logic rr;

    // A lone requester always wins; on contention the pointer decides.
    always_comb begin
        gnt[0] = req[0] & (~req[1] | (rr == PORT_CPU));
        gnt[1] = req[1] & (~req[0] | (rr == PORT_LOAD));
    end

    // After every accept, point at the port that was not just served.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset)
            rr <= PORT_CPU;
        else if (accept)
            rr <= gnt[0] ? PORT_LOAD : PORT_CPU;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port dmem between CPU (port 0) and loader (port 1), registered outputs, 2-cycle read return
// Ports:
//   clock, ctrl_reset          : clock, asynchronous active-low reset
//   req/we/addr/wdata 0 and 1  : per-port request (held stable until accepted)
//   gnt0, gnt1                 : combinational one-hot grant
//   rvalid0, rvalid1, rdata    : read response, rdata shared and qualified by rvalidK
//   dmem_address/data/wren     : registered dmem pins
//   dmem_q                     : dmem read data, passed straight through to rdata
module dmem_arbiter #(
    parameter int ADDR_W = dmem_arb_pkg::ADDR_W,
    parameter int DATA_W = dmem_arb_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] dmem_address,
    output logic [DATA_W-1:0] dmem_data,
    output logic              dmem_wren,
    input  logic [DATA_W-1:0] dmem_q
);
    import dmem_arb_pkg::tag_t;
    import dmem_arb_pkg::PORT_CPU;
    import dmem_arb_pkg::PORT_LOAD;

    logic [1:0] gnt;
    logic       accept;
    logic       win;
    logic       win_we;
    tag_t       s1;
    tag_t       s2;

    rr_arbiter2 u_rr (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .req        ({req1, req0}),
        .accept     (accept),
        .gnt        (gnt)
    );

    // Grants are only offered to requesting ports, so any grant is an accept.
    always_comb begin
        gnt0   = gnt[0];
        gnt1   = gnt[1];
        accept = |gnt;
        win    = gnt[1] ? PORT_LOAD : PORT_CPU;
        win_we = gnt[1] ? we1 : we0;
    end

    // Stage 1 tags the read at its accept edge; stage 2 lines up with dmem_q.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            dmem_wren    <= 1'b0;
            dmem_address <= '0;
            dmem_data    <= '0;
            s1           <= '0;
            s2           <= '0;
        end else begin
            dmem_wren <= accept & win_we;
            if (accept) begin
                dmem_address <= gnt[1] ? addr1 : addr0;
                dmem_data    <= gnt[1] ? wdata1 : wdata0;
            end
            s1.valid <= accept & ~win_we;
            s1.port  <= win;
            s2       <= s1;
        end
    end

    always_comb begin
        rvalid0 = s2.valid & (s2.port == PORT_CPU);
        rvalid1 = s2.valid & (s2.port == PORT_LOAD);
        rdata   = dmem_q;
    end

endmodule
